// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared definitions for the Gray-code receiver: tracking
//                FSM state encoding and the width of the advance counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

   // Receiver FSM: SYNC waits for a sample to lock onto, TRACK checks each
   // new sample against the last accepted one.
   typedef enum logic {
      SYNC  = 1'b0,
      TRACK = 1'b1
   } state_e;

   // Width of the saturating count of legal advances.
   localparam int COUNT_W = 8;

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// ============================================================================
//  Module      : gray2bin
//  Description : Purely combinational Gray-to-binary converter.
//                Bit i of the binary result is the XOR of Gray bits
//                WIDTH-1 down to i, which equals the MSB-first ripple
//                b[i] = b[i+1] ^ g[i]; computing each bit independently
//                avoids a self-referencing vector.
//  Ports       : i_gray [WIDTH-1:0]  Gray code word
//                o_bin  [WIDTH-1:0]  equivalent binary value
//  Revision    : 1.0 - initial release
// ============================================================================
module gray2bin #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign o_bin[i] = ^(i_gray >> i);
   end

endmodule : gray2bin
`default_nettype wire

// File: rtl/gray_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : gray_receiver
//  Description : Receives Gray-coded samples from an upstream Gray counter,
//                converts them to binary, and checks that successive
//                accepted samples either hold or advance by exactly one
//                (modulo 2^WIDTH). Flags wraps and illegal jumps, and keeps a
//                saturating count of legal advances since the last lock.
//                All outputs are registered; latency is one clock.
//  Ports       : Clk       clock, rising edge active
//                Reset_n   synchronous active-low reset
//                En        sample strobe for Gray_in
//                Gray_in   [WIDTH-1:0] incoming Gray code
//                Binary    [WIDTH-1:0] last accepted value (binary)
//                Valid     one-cycle pulse, Binary refreshed
//                Wrap      one-cycle pulse, advance from max to 0
//                Overflow  sticky, set on first wrap
//                Error     sticky, set on first illegal transition
//                Count     [7:0] saturating count of legal advances
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_receiver
   import gray_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  En,
   input  logic [WIDTH-1:0]      Gray_in,
   output logic [WIDTH-1:0]      Binary,
   output logic                  Valid,
   output logic                  Wrap,
   output logic                  Overflow,
   output logic                  Error,
   output logic [COUNT_W-1:0]    Count
);

   localparam logic [WIDTH-1:0]   C_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_W-1:0] C_COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
   localparam logic [COUNT_W-1:0] C_COUNT_MAX = '1;

   state_e               state_q,    state_d;
   // The previous accepted value and the Binary output are always identical,
   // so one register serves as both.
   logic [WIDTH-1:0]     binary_q,   binary_d;
   logic                 valid_q,    valid_d;
   logic                 wrap_q,     wrap_d;
   logic                 overflow_q, overflow_d;
   logic                 error_q,    error_d;
   logic [COUNT_W-1:0]   count_q,    count_d;

   logic [WIDTH-1:0]     w_bin;
   logic [WIDTH-1:0]     w_expected;
   logic                 w_is_hold;
   logic                 w_is_advance;

   gray2bin #(
      .WIDTH (WIDTH)
   ) u_gray2bin (
      .i_gray (Gray_in),
      .o_bin  (w_bin)
   );

   assign w_expected   = binary_q + C_ONE;   // wraps naturally mod 2^WIDTH
   assign w_is_hold    = (w_bin == binary_q);
   assign w_is_advance = (w_bin == w_expected);

   always_comb begin
      state_d    = state_q;
      binary_d   = binary_q;
      valid_d    = 1'b0;
      wrap_d     = 1'b0;
      overflow_d = overflow_q;
      error_d    = error_q;
      count_d    = count_q;

      if (En) begin
         unique case (state_q)
            SYNC: begin
               // Lock onto whatever arrives; no history to check against.
               binary_d = w_bin;
               valid_d  = 1'b1;
               count_d  = '0;
               state_d  = TRACK;
            end
            TRACK: begin
               if (w_is_hold) begin
                  valid_d = 1'b1;
               end else if (w_is_advance) begin
                  binary_d = w_bin;
                  valid_d  = 1'b1;
                  if (count_q != C_COUNT_MAX) begin
                     count_d = count_q + C_COUNT_ONE;
                  end
                  // An advance whose predecessor is all ones lands on zero.
                  if (&binary_q) begin
                     wrap_d     = 1'b1;
                     overflow_d = 1'b1;
                  end
               end else begin
                  error_d = 1'b1;
                  state_d = SYNC;
               end
            end
            default: state_d = SYNC;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q    <= SYNC;
         binary_q   <= '0;
         valid_q    <= 1'b0;
         wrap_q     <= 1'b0;
         overflow_q <= 1'b0;
         error_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         binary_q   <= binary_d;
         valid_q    <= valid_d;
         wrap_q     <= wrap_d;
         overflow_q <= overflow_d;
         error_q    <= error_d;
         count_q    <= count_d;
      end
   end

   assign Binary   = binary_q;
   assign Valid    = valid_q;
   assign Wrap     = wrap_q;
   assign Overflow = overflow_q;
   assign Error    = error_q;
   assign Count    = count_q;

endmodule : gray_receiver
`default_nettype wire

// File: tb/tb_gray_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_receiver
//  Description : Self-checking bench for gray_receiver (WIDTH=3): a table of
//                directed vectors with hand-computed expectations, followed
//                by a long run of legal advances exercising Count saturation
//                and repeated wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_receiver;

   localparam int WIDTH = 3;

   typedef struct {
      logic             rst_n;
      logic             en;
      logic [WIDTH-1:0] gray;
      logic [WIDTH-1:0] b;
      logic             v;
      logic             w;
      logic             o;
      logic             e;
      logic [7:0]       c;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic [WIDTH-1:0] gray_in;
   logic [WIDTH-1:0] binary;
   logic             valid;
   logic             wrap;
   logic             overflow;
   logic             error;
   logic [7:0]       count;

   int checks   = 0;
   int failures = 0;

   vec_t vecs[$];

   gray_receiver #(
      .WIDTH (WIDTH)
   ) dut (
      .Clk      (clk),
      .Reset_n  (rst_n),
      .En       (en),
      .Gray_in  (gray_in),
      .Binary   (binary),
      .Valid    (valid),
      .Wrap     (wrap),
      .Overflow (overflow),
      .Error    (error),
      .Count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx,
                        input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic e_n, input logic [2:0] g,
                      input logic [2:0] b, input logic v, input logic w,
                      input logic o, input logic e, input logic [7:0] c);
      vec_t t;
      t.rst_n = r; t.en = e_n; t.gray = g; t.b = b;
      t.v = v; t.w = w; t.o = o; t.e = e; t.c = c;
      vecs.push_back(t);
   endtask

   task automatic check_all(input int idx, input logic [2:0] b, input logic v,
                            input logic w, input logic o, input logic e,
                            input logic [7:0] c);
      check("binary",   idx, {5'd0, binary}, {5'd0, b});
      check("valid",    idx, {7'd0, valid},  {7'd0, v});
      check("wrap",     idx, {7'd0, wrap},   {7'd0, w});
      check("overflow", idx, {7'd0, overflow}, {7'd0, o});
      check("error",    idx, {7'd0, error},  {7'd0, e});
      check("count",    idx, count, c);
   endtask

   task automatic step(input logic r, input logic e_n, input logic [2:0] g);
      @(negedge clk);
      rst_n   = r;
      en      = e_n;
      gray_in = g;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] bb;
      logic [2:0] gg;
      logic [7:0] exp_c;

      rst_n = 1'b0; en = 1'b0; gray_in = '0;

      //  rst en gray    bin  V  W  O  E  Count
      // Reset state, then a sample coinciding with reset is discarded
      add(0, 0, 3'b000, 3'd0, 0, 0, 0, 0, 8'd0);
      add(0, 1, 3'b011, 3'd0, 0, 0, 0, 0, 8'd0);
      // Full Gray cycle ending in a wrap
      add(1, 1, 3'b000, 3'd0, 1, 0, 0, 0, 8'd0);
      add(1, 1, 3'b001, 3'd1, 1, 0, 0, 0, 8'd1);
      add(1, 1, 3'b011, 3'd2, 1, 0, 0, 0, 8'd2);
      add(1, 1, 3'b010, 3'd3, 1, 0, 0, 0, 8'd3);
      add(1, 1, 3'b110, 3'd4, 1, 0, 0, 0, 8'd4);
      add(1, 1, 3'b111, 3'd5, 1, 0, 0, 0, 8'd5);
      add(1, 1, 3'b101, 3'd6, 1, 0, 0, 0, 8'd6);
      add(1, 1, 3'b100, 3'd7, 1, 0, 0, 0, 8'd7);
      add(1, 1, 3'b000, 3'd0, 1, 1, 1, 0, 8'd8);
      // Advance to 2 then hold three times
      add(1, 1, 3'b001, 3'd1, 1, 0, 1, 0, 8'd9);
      add(1, 1, 3'b011, 3'd2, 1, 0, 1, 0, 8'd10);
      add(1, 1, 3'b011, 3'd2, 1, 0, 1, 0, 8'd10);
      add(1, 1, 3'b011, 3'd2, 1, 0, 1, 0, 8'd10);
      add(1, 1, 3'b011, 3'd2, 1, 0, 1, 0, 8'd10);
      // Illegal jump 2->4, relock on 1, illegal 1->4, relock on 5
      add(1, 1, 3'b110, 3'd2, 0, 0, 1, 1, 8'd10);
      add(1, 1, 3'b001, 3'd1, 1, 0, 1, 1, 8'd0);
      add(1, 1, 3'b110, 3'd1, 0, 0, 1, 1, 8'd0);
      add(1, 1, 3'b111, 3'd5, 1, 0, 1, 1, 8'd0);
      // En gating with toggling input
      add(1, 0, 3'b010, 3'd5, 0, 0, 1, 1, 8'd0);
      add(1, 0, 3'b101, 3'd5, 0, 0, 1, 1, 8'd0);
      add(1, 0, 3'b000, 3'd5, 0, 0, 1, 1, 8'd0);
      add(1, 0, 3'b111, 3'd5, 0, 0, 1, 1, 8'd0);
      add(1, 0, 3'b011, 3'd5, 0, 0, 1, 1, 8'd0);
      // Nine advances from 5 (including a second wrap) to Count=9
      add(1, 1, 3'b101, 3'd6, 1, 0, 1, 1, 8'd1);
      add(1, 1, 3'b100, 3'd7, 1, 0, 1, 1, 8'd2);
      add(1, 1, 3'b000, 3'd0, 1, 1, 1, 1, 8'd3);
      add(1, 1, 3'b001, 3'd1, 1, 0, 1, 1, 8'd4);
      add(1, 1, 3'b011, 3'd2, 1, 0, 1, 1, 8'd5);
      add(1, 1, 3'b010, 3'd3, 1, 0, 1, 1, 8'd6);
      add(1, 1, 3'b110, 3'd4, 1, 0, 1, 1, 8'd7);
      add(1, 1, 3'b111, 3'd5, 1, 0, 1, 1, 8'd8);
      add(1, 1, 3'b101, 3'd6, 1, 0, 1, 1, 8'd9);
      // Reset mid-operation clears everything; next sample relocks unchecked
      add(0, 1, 3'b000, 3'd0, 0, 0, 0, 0, 8'd0);
      add(1, 1, 3'b101, 3'd6, 1, 0, 0, 0, 8'd0);
      add(1, 0, 3'b000, 3'd6, 0, 0, 0, 0, 8'd0);

      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].en, vecs[i].gray);
         check_all(i, vecs[i].b, vecs[i].v, vecs[i].w, vecs[i].o,
                   vecs[i].e, vecs[i].c);
      end

      // Saturation: reset, lock on 0, then 300 legal advances
      step(1'b0, 1'b0, 3'b000);
      check_all(1000, 3'd0, 0, 0, 0, 0, 8'd0);
      step(1'b1, 1'b1, 3'b000);
      check_all(1001, 3'd0, 1, 0, 0, 0, 8'd0);
      for (int i = 0; i < 300; i++) begin
         bb    = 3'((i + 1) % 8);
         gg    = bb ^ (bb >> 1);
         exp_c = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
         step(1'b1, 1'b1, gg);
         check_all(2000 + i, bb, 1'b1, (bb == 3'd0), (i >= 7), 1'b0, exp_c);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_gray_receiver
`default_nettype wire

// File: doc/gray_receiver.md
GRAY_RECEIVER -- requirements
Module: gray_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 3, meaning the Gray code width in bits (legal range 2..8).
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1, synchronous active-low reset, sampled on rising Clk.
REQ-004 SHALL have port En, input, 1, sample strobe; Gray_in is accepted only on cycles where En=1.
REQ-005 SHALL have port Gray_in, input, WIDTH, the incoming Gray code word from the upstream Gray counter.
REQ-006 SHALL have port Binary, output, WIDTH, the registered binary value of the last accepted code.
REQ-007 SHALL have port Valid, output, 1, a one-cycle pulse marking Binary as updated.
REQ-008 SHALL have port Wrap, output, 1, a one-cycle pulse coincident with Valid when the sequence wrapped from max to 0.
REQ-009 SHALL have port Overflow, output, 1, sticky flag, set on the first Wrap and held until reset.
REQ-010 SHALL have port Error, output, 1, sticky flag, set on the first illegal transition and held until reset.
REQ-011 SHALL have port Count, output, 8, saturating count of legal advances since the last lock.

Function
REQ-012 SHALL convert codes combinationally: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1] XOR g[i] for i from WIDTH-2 down to 0.
REQ-013 SHALL implement FSM states SYNC and TRACK; reset state is SYNC.
REQ-014 SHALL, in SYNC with En=1: store the converted value as prev, drive Binary=value, pulse Valid, clear Count to 0, and move to TRACK; no legality check is made.
REQ-015 SHALL, in TRACK with En=1, classify new binary n against prev p as HOLD (n==p), ADVANCE (n==(p+1) mod 2^WIDTH) or ILLEGAL (any other value).
REQ-016 SHALL, on HOLD: leave Binary, Count and flags unchanged, and pulse Valid.
REQ-017 SHALL, on ADVANCE: update prev and Binary to n, pulse Valid, and increment Count, saturating at 255.
REQ-018 SHALL, on an ADVANCE with p==2^WIDTH-1 and n==0: pulse Wrap and set Overflow, in the same cycle as Valid.
REQ-019 SHALL, on ILLEGAL: set Error, leave Binary unchanged, not pulse Valid or Wrap, and return to SYNC so the next sample relocks.
REQ-020 SHALL keep all state and outputs unchanged when En=0, with Valid and Wrap driven 0.
REQ-021 SHALL have a latency of exactly 1 cycle: an En sample at edge k is reflected on Binary, Valid and Wrap after edge k.
REQ-022 SHALL produce only registered outputs, with no combinational path from inputs to outputs.
REQ-023 SHALL treat a repeated wrap as not re-pulsing Overflow (it stays 1) while Wrap pulses on every wrap.

Reset
REQ-024 SHALL, when Reset_n=0 at a rising edge, force the state to SYNC and set Binary=0, prev=0, Valid=0, Wrap=0, Overflow=0, Error=0, Count=0, regardless of En.
REQ-025 SHALL give reset priority over En; a sample that coincides with reset is discarded.
REQ-026 SHALL make reset mid-sequence discard all history; the first sample after reset relocks without any check.

Structure
REQ-027 SHALL place the FSM state encoding (SYNC=1'b0, TRACK=1'b1) and the Count width constant (8) in the shared package gray_pkg.
REQ-028 SHALL place the Gray-to-binary conversion in a combinational sub-module gray2bin, parameterised by WIDTH.

Verification (WIDTH=3)
REQ-029 SHALL verify full cycle: reset, then En=1 with Gray_in 000,001,011,010,110,111,101,100,000 gives Binary 0..7,0, Valid on every sample, Wrap and Overflow=1 only on the final sample, and Count=8.
REQ-030 SHALL verify HOLD: Gray_in 011,011,011 after lock gives Binary=2 held, Valid=1 each cycle, Count unchanged, Error=0.
REQ-031 SHALL verify illegal jump: after lock on 001, Gray_in 110 gives Error=1, no Valid, Binary=1; then Gray_in 111 relocks with Binary=5, Valid=1 and Count=0.
REQ-032 SHALL verify En gating: with En=0 and Gray_in toggling arbitrarily for 5 cycles, all outputs are unchanged and Valid=0.
REQ-033 SHALL verify reset mid-operation: with Overflow=1, Error=1 and Count=9, Reset_n=0 for 1 cycle gives all outputs 0; then Gray_in 101 locks with Binary=6 and no Error.
REQ-034 SHALL verify Count saturation: 300 consecutive legal advances give Count=255 and Overflow=1.
